// File: rtl/wrr_grant_arbiter.sv
// Weighted round-robin grant arbiter with a registered one-hot grant and index; one-cycle decision latency.
// No backpressure: requesters hold req until served, and weights may be rewritten at any cycle.
module wrr_grant_arbiter #(
    parameter int N        = 32,
    parameter int ID_W     = 5,
    parameter int WEIGHT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic                cfg_we,
    input  logic [ID_W-1:0]     cfg_id,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    output logic [N-1:0]        gnt_w,
    output logic [ID_W-1:0]     gnt_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                     state;
    logic [ID_W-1:0]            ptr;
    logic [WEIGHT_W:0]          cnt;
    logic [N-1:0][WEIGHT_W-1:0] weight;

    logic [ID_W-1:0]            nxt_owner;
    logic [ID_W-1:0]            scan_start;
    logic [ID_W-1:0]            scan_idx;
    logic [N-1:0]               scan_oh;
    logic                       scan_vld;
    logic [WEIGHT_W:0]          owner_weff;
    logic                       keep;

    // The owner is simply gnt_id while in GRANT; a zero weight behaves as one.
    always_comb begin
        nxt_owner  = (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
        scan_start = (state == GRANT) ? nxt_owner : ptr;
        owner_weff = (weight[gnt_id] == '0) ? (WEIGHT_W + 1)'(1) : {1'b0, weight[gnt_id]};
        keep       = (state == GRANT) && req[gnt_id] && (cnt < owner_weff);
    end

    // Circular scan starting at scan_start; starting past the owner puts the owner last.
    always_comb begin
        int idx;
        idx      = 0;
        scan_vld = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(scan_start) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!scan_vld && req[idx]) begin
                scan_vld = 1'b1;
                scan_idx = ID_W'(idx);
            end
        end
        scan_oh = {{(N - 1){1'b0}}, 1'b1} << scan_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            gnt_w  <= '0;
            gnt_id <= '0;
            for (int i = 0; i < N; i++) begin
                weight[i] <= WEIGHT_W'(1);
            end
        end else begin
            if (cfg_we) begin
                weight[cfg_id] <= cfg_weight;
            end
            case (state)
                IDLE: begin
                    if (scan_vld) begin
                        state  <= GRANT;
                        gnt_w  <= scan_oh;
                        gnt_id <= scan_idx;
                        cnt    <= (WEIGHT_W + 1)'(1);
                    end
                end
                GRANT: begin
                    if (keep) begin
                        cnt <= cnt + 1'b1;
                    end else if (scan_vld) begin
                        gnt_w  <= scan_oh;
                        gnt_id <= scan_idx;
                        cnt    <= (WEIGHT_W + 1)'(1);
                    end else begin
                        state  <= IDLE;
                        gnt_w  <= '0;
                        gnt_id <= '0;
                        cnt    <= '0;
                        ptr    <= nxt_owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_w));
    a_id_match: assert property (@(posedge clk) disable iff (rst) (gnt_w != '0) |-> gnt_w[gnt_id]);
    a_id_zero:  assert property (@(posedge clk) disable iff (rst) (gnt_w == '0) |-> (gnt_id == '0));
`endif

endmodule

// File: tb/tb_wrr_grant_arbiter.sv
// Directed bench for wrr_grant_arbiter: hand-computed grant sequences per scenario.
module tb_wrr_grant_arbiter;
    localparam int N        = 32;
    localparam int ID_W     = 5;
    localparam int WEIGHT_W = 4;

    logic                clk;
    logic                rst;
    logic [N-1:0]        req;
    logic                cfg_we;
    logic [ID_W-1:0]     cfg_id;
    logic [WEIGHT_W-1:0] cfg_weight;
    logic [N-1:0]        gnt_w;
    logic [ID_W-1:0]     gnt_id;

    int tests_run;
    int tests_failed;

    wrr_grant_arbiter #(.N(N), .ID_W(ID_W), .WEIGHT_W(WEIGHT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .cfg_we     (cfg_we),
        .cfg_id     (cfg_id),
        .cfg_weight (cfg_weight),
        .gnt_w      (gnt_w),
        .gnt_id     (gnt_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [N-1:0] oh(input int id);
        logic [N-1:0] one;
        one = 1;
        return one << id;
    endfunction

    // Inputs change on the falling edge; outputs are read on the following falling edge.
    task automatic apply_reset();
        @(negedge clk);
        req    = '0;
        cfg_we = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_weight(input int id, input int w);
        cfg_we     = 1'b1;
        cfg_id     = ID_W'(id);
        cfg_weight = WEIGHT_W'(w);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (gnt_w !== '0 || gnt_id !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: gnt_w=%h gnt_id=%0d, want 0/0", gnt_w, gnt_id);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests_run++;
            if (gnt_w !== '0 || gnt_id !== '0) begin
                tests_failed++;
                $display("FAIL idle_cycle%0d: gnt_w=%h gnt_id=%0d, want 0/0", c, gnt_w, gnt_id);
            end
        end
        req = oh(5);
        @(negedge clk);
        tests_run++;
        if (gnt_w !== oh(5) || gnt_id !== 5) begin
            tests_failed++;
            $display("FAIL pre_async_grant: gnt_w=%h gnt_id=%0d, want %h/5", gnt_w, gnt_id, oh(5));
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (gnt_w !== '0 || gnt_id !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: gnt_w=%h gnt_id=%0d, want 0/0", gnt_w, gnt_id);
        end
        @(negedge clk);
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_equal_rotation();
        apply_reset();
        req = '1;
        for (int k = 0; k <= N; k++) begin
            @(negedge clk);
            tests_run++;
            if (gnt_id !== ID_W'(k % N) || gnt_w !== oh(k % N)) begin
                tests_failed++;
                $display("FAIL rotation_step%0d: gnt_id=%0d gnt_w=%h, want %0d/%h",
                         k, gnt_id, gnt_w, k % N, oh(k % N));
            end
        end
        req = '0;
        @(negedge clk);
        tests_run++;
        if (gnt_w !== '0 || gnt_id !== '0) begin
            tests_failed++;
            $display("FAIL rotation_release: gnt_w=%h gnt_id=%0d, want 0/0", gnt_w, gnt_id);
        end
    endtask

    task automatic test_weighted_burst();
        int exp_seq[6] = '{2, 2, 2, 5, 9, 9};
        apply_reset();
        write_weight(2, 3);
        write_weight(5, 1);
        write_weight(9, 2);
        req = oh(2) | oh(5) | oh(9);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            tests_run++;
            if (gnt_id !== ID_W'(exp_seq[k % 6]) || gnt_w !== oh(exp_seq[k % 6])) begin
                tests_failed++;
                $display("FAIL weighted_step%0d: gnt_id=%0d, want %0d", k, gnt_id, exp_seq[k % 6]);
            end
        end
    endtask

    task automatic test_req_drop();
        int exp_seq[7] = '{4, 4, 4, 7, 7, 7, 4};
        apply_reset();
        write_weight(4, 8);
        write_weight(7, 3);
        req = oh(4) | oh(7);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            tests_run++;
            if (gnt_id !== ID_W'(exp_seq[k]) || gnt_w !== oh(exp_seq[k])) begin
                tests_failed++;
                $display("FAIL drop_step%0d: gnt_id=%0d, want %0d", k, gnt_id, exp_seq[k]);
            end
            if (k == 2) req = oh(7);
            if (k == 3) req = oh(4) | oh(7);
        end
    endtask

    task automatic test_wrap_single();
        int exp_seq[10] = '{31, 31, 31, 31, 0, 31, 31, 0, 31, 31};
        apply_reset();
        write_weight(31, 2);
        req = oh(31);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            tests_run++;
            if (gnt_id !== ID_W'(exp_seq[k]) || gnt_w !== oh(exp_seq[k])) begin
                tests_failed++;
                $display("FAIL wrap_step%0d: gnt_id=%0d, want %0d", k, gnt_id, exp_seq[k]);
            end
            if (k == 2) req = oh(31) | oh(0);
        end
    endtask

    task automatic test_config_edge();
        int exp_seq[7] = '{3, 3, 3, 3, 10, 3, 10};
        int post_rst[3] = '{3, 10, 3};
        apply_reset();
        write_weight(3, 6);
        req = oh(3) | oh(10);
        for (int k = 0; k < 7; k++) begin
            if (k == 3) begin
                write_weight(3, 0);
            end else begin
                @(negedge clk);
            end
            tests_run++;
            if (gnt_id !== ID_W'(exp_seq[k]) || gnt_w !== oh(exp_seq[k])) begin
                tests_failed++;
                $display("FAIL cfg_step%0d: gnt_id=%0d, want %0d", k, gnt_id, exp_seq[k]);
            end
        end
        req = oh(3);
        write_weight(3, 5);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (gnt_id !== 3 || gnt_w !== oh(3)) begin
            tests_failed++;
            $display("FAIL cfg_burst_before_rst: gnt_id=%0d, want 3", gnt_id);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (gnt_w !== '0 || gnt_id !== '0) begin
            tests_failed++;
            $display("FAIL midburst_reset: gnt_w=%h gnt_id=%0d, want 0/0", gnt_w, gnt_id);
        end
        @(negedge clk);
        rst = 1'b0;
        req = oh(3) | oh(10);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (gnt_id !== ID_W'(post_rst[k]) || gnt_w !== oh(post_rst[k])) begin
                tests_failed++;
                $display("FAIL weight_after_rst_step%0d: gnt_id=%0d, want %0d", k, gnt_id, post_rst[k]);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        req          = '0;
        cfg_we       = 1'b0;
        cfg_id       = '0;
        cfg_weight   = '0;
        test_reset();
        test_equal_rotation();
        test_weighted_burst();
        test_req_drop();
        test_wrap_single();
        test_config_edge();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
